// File: rtl/l1_dcache_dm_if.sv
// CPU D-side request bus plus the line-wide physical-memory port of the L1 data cache.
// master = CPU core and memory side, slave = the cache.
interface l1_dcache_dm_if;
  logic         mem_read;
  logic         mem_write;
  logic [3:0]   mem_byte_enable;
  logic [31:0]  mem_address;
  logic [31:0]  mem_wdata;
  logic         mem_resp;
  logic [31:0]  mem_rdata;
  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic         pmem_resp;
  logic [255:0] pmem_rdata;

  modport master (
    output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    output pmem_resp, pmem_rdata,
    input  mem_resp, mem_rdata,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata
  );

  modport slave (
    input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    input  pmem_resp, pmem_rdata,
    output mem_resp, mem_rdata,
    output pmem_read, pmem_write, pmem_address, pmem_wdata
  );
endinterface

// File: rtl/l1_dcache_dm.sv
// Direct-mapped write-back/write-allocate L1 D-cache: zero-cycle hits, misses fill 256-bit lines.
// CPU waits by holding its request until mem_resp; pmem requests are held until pmem_resp.
module l1_dcache_dm #(
  parameter int S_INDEX  = 3,
  parameter int S_OFFSET = 5,
  parameter int S_TAG    = 32 - S_INDEX - S_OFFSET
) (
  input  logic           clk,
  input  logic           rst,
  l1_dcache_dm_if.slave  io_bus
);
  localparam int N_SETS = 1 << S_INDEX;

  typedef enum logic [1:0] {
    CHECK     = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [N_SETS-1:0] r_valid;
  logic [N_SETS-1:0] r_dirty;
  logic [S_TAG-1:0]  r_tag  [N_SETS];
  logic [255:0]      r_data [N_SETS];

  logic [S_INDEX-1:0] w_index;
  logic [2:0]         w_word;
  logic [S_TAG-1:0]   w_tag;
  logic               w_req;
  logic               w_hit;
  logic               w_wr_hit;
  logic [255:0]       w_line;
  logic [31:0]        w_cur_word;
  logic [31:0]        w_merged;
  logic               w_resp;
  logic               w_pmem_read;
  logic               w_pmem_write;
  logic [31:0]        w_pmem_address;
  logic [255:0]       w_pmem_wdata;
  logic               w_unused;

  assign w_index    = io_bus.mem_address[S_OFFSET+S_INDEX-1:S_OFFSET];
  assign w_word     = io_bus.mem_address[4:2];
  assign w_tag      = io_bus.mem_address[31:S_OFFSET+S_INDEX];
  assign w_unused   = ^io_bus.mem_address[1:0];
  assign w_req      = io_bus.mem_read | io_bus.mem_write;
  assign w_hit      = r_valid[w_index] && (r_tag[w_index] == w_tag);
  assign w_wr_hit   = (r_state == CHECK) && io_bus.mem_write && w_hit;
  assign w_line     = r_data[w_index];
  assign w_cur_word = w_line[{w_word, 5'b0} +: 32];

  always_comb begin
    w_merged = w_cur_word;
    for (int b = 0; b < 4; b++) begin
      if (io_bus.mem_byte_enable[b]) begin
        w_merged[b*8 +: 8] = io_bus.mem_wdata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= CHECK;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Status bits reset asynchronously; tag/data arrays below are never reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else begin
      case (r_state)
        CHECK: begin
          if (w_wr_hit) r_dirty[w_index] <= 1'b1;
        end
        WRITEBACK: begin
          if (io_bus.pmem_resp) r_dirty[w_index] <= 1'b0;
        end
        ALLOCATE: begin
          if (io_bus.pmem_resp) begin
            r_valid[w_index] <= 1'b1;
            r_dirty[w_index] <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_hit) begin
      r_data[w_index][{w_word, 5'b0} +: 32] <= w_merged;
    end else if ((r_state == ALLOCATE) && io_bus.pmem_resp) begin
      r_data[w_index] <= io_bus.pmem_rdata;
      r_tag[w_index]  <= w_tag;
    end
  end

  always_comb begin
    w_next_state   = r_state;
    w_resp         = 1'b0;
    w_pmem_read    = 1'b0;
    w_pmem_write   = 1'b0;
    w_pmem_address = '0;
    w_pmem_wdata   = '0;
    case (r_state)
      CHECK: begin
        if (w_req) begin
          if (w_hit) begin
            w_resp = 1'b1;
          end else if (r_valid[w_index] && r_dirty[w_index]) begin
            w_next_state = WRITEBACK;
          end else begin
            w_next_state = ALLOCATE;
          end
        end
      end
      WRITEBACK: begin
        w_pmem_write   = 1'b1;
        w_pmem_address = {r_tag[w_index], w_index, {S_OFFSET{1'b0}}};
        w_pmem_wdata   = w_line;
        if (io_bus.pmem_resp) w_next_state = ALLOCATE;
      end
      ALLOCATE: begin
        w_pmem_read    = 1'b1;
        w_pmem_address = {io_bus.mem_address[31:S_OFFSET], {S_OFFSET{1'b0}}};
        if (io_bus.pmem_resp) w_next_state = CHECK;
      end
      default: w_next_state = CHECK;
    endcase
  end

  // Gating with rst makes the request/response strobes fall without waiting for a clock.
  assign io_bus.mem_resp     = w_resp & ~rst;
  assign io_bus.mem_rdata    = io_bus.mem_resp ? w_cur_word : 32'h0;
  assign io_bus.pmem_read    = w_pmem_read & ~rst;
  assign io_bus.pmem_write   = w_pmem_write & ~rst;
  assign io_bus.pmem_address = w_pmem_address;
  assign io_bus.pmem_wdata   = w_pmem_wdata;
endmodule

// File: tb/tb_l1_dcache_dm.sv
// Directed plus random bench for l1_dcache_dm against a line-level memory/cache reference model.
module tb_l1_dcache_dm;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  l1_dcache_dm_if bus ();
  l1_dcache_dm dut (.clk(clk), .rst(rst), .io_bus(bus));

  int checks = 0;
  int errors = 0;

  // backing: what physical memory holds; golden: what the CPU should observe.
  logic [255:0] backing [logic [26:0]];
  logic [255:0] golden  [logic [26:0]];
  bit           m_valid [8];
  bit           m_dirty [8];
  logic [26:0]  m_line  [8];

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  task automatic ensure(input logic [26:0] la);
    logic [255:0] l;
    if (!backing.exists(la)) begin
      l = rand_line();
      backing[la] = l;
      golden[la]  = l;
    end
  endtask

  task automatic preload_word1(input logic [31:0] addr, input logic [31:0] w1);
    logic [255:0] l;
    l = rand_line();
    l[63:32] = w1;
    backing[addr[31:5]] = l;
    golden[addr[31:5]]  = l;
  endtask

  task automatic model_reset();
    for (int s = 0; s < 8; s++) begin
      if (m_valid[s] && m_dirty[s]) golden[m_line[s]] = backing[m_line[s]];
      m_valid[s] = 1'b0;
      m_dirty[s] = 1'b0;
    end
  endtask

  task automatic access(input bit wr, input bit rd_too, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] be);
    logic [26:0]  la;
    int           si, word, wait_ctr, fill_cyc, wb_cyc;
    bit           exp_miss, exp_wb, saw_wb, saw_rd, pend, done;
    logic [26:0]  vic_la;
    logic [255:0] vic_line, cur;
    logic [31:0]  exp_rd;
    la   = addr[31:5];
    si   = int'(addr[7:5]);
    word = int'(addr[4:2]);
    ensure(la);
    exp_miss = !(m_valid[si] && m_line[si] == la);
    exp_wb   = exp_miss && m_valid[si] && m_dirty[si];
    vic_la   = m_line[si];
    vic_line = exp_wb ? golden[vic_la] : '0;
    cur      = golden[la];
    exp_rd   = cur[word*32 +: 32];

    @(negedge clk);
    bus.mem_read        = !wr || rd_too;
    bus.mem_write       = wr;
    bus.mem_address     = addr;
    bus.mem_wdata       = wd;
    bus.mem_byte_enable = be;
    saw_wb = 0; saw_rd = 0; pend = 0; done = 0;
    wait_ctr = 0; fill_cyc = -10; wb_cyc = -10;
    for (int cyc = 0; cyc < 200; cyc++) begin
      #1;
      if (cyc == 0) chk("hit_same_cycle", bus.mem_resp, !exp_miss);
      if (bus.mem_resp) begin
        if (exp_miss) chk("miss_latency", cyc, fill_cyc + 1);
        chk("fill_issued", saw_rd, exp_miss);
        chk("wb_issued", saw_wb, exp_wb);
        if (!wr) chk("rdata", bus.mem_rdata, exp_rd);
        done = 1;
        break;
      end
      if (bus.pmem_read || bus.pmem_write) begin
        if (!pend) begin
          chk("rw_exclusive", bus.pmem_read & bus.pmem_write, 1'b0);
          chk("rdata_zero_no_resp", bus.mem_rdata, 32'h0);
          if (bus.pmem_write) begin
            chk("wb_expected", bus.pmem_write, exp_wb);
            if (exp_wb) begin
              chk("wb_addr", bus.pmem_address, {vic_la, 5'b0});
              chk("wb_data", bus.pmem_wdata, vic_line);
            end
            saw_wb = 1;
          end else begin
            chk("fill_expected", bus.pmem_read, exp_miss);
            chk("fill_addr", bus.pmem_address, {la, 5'b0});
            if (exp_wb) chk("wb_then_fill", cyc, wb_cyc + 1);
            saw_rd = 1;
          end
          pend = 1;
          wait_ctr = $urandom_range(0, 3);
        end
        if (wait_ctr == 0) begin
          bus.pmem_resp = 1'b1;
          pend = 0;
          if (bus.pmem_write) begin
            backing[bus.pmem_address[31:5]] = bus.pmem_wdata;
            wb_cyc = cyc;
          end else begin
            ensure(bus.pmem_address[31:5]);
            bus.pmem_rdata = backing[bus.pmem_address[31:5]];
            fill_cyc = cyc;
          end
        end else begin
          wait_ctr--;
        end
      end
      @(negedge clk);
      bus.pmem_resp = 1'b0;
    end
    bus.pmem_resp = 1'b0;
    chk("completed", done, 1'b1);

    if (exp_miss) begin
      m_valid[si] = 1'b1;
      m_line[si]  = la;
      m_dirty[si] = 1'b0;
    end
    if (wr) begin
      cur = golden[la];
      for (int b = 0; b < 4; b++) begin
        if (be[b]) cur[word*32 + b*8 +: 8] = wd[b*8 +: 8];
      end
      golden[la]  = cur;
      m_dirty[si] = 1'b1;
    end
    @(negedge clk);
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] addr;
    bit          wr, rd_too, seen;

    rst = 1'b1;
    bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.mem_byte_enable = 4'h0;
    bus.mem_address = 32'h0; bus.mem_wdata = 32'h0;
    bus.pmem_resp = 1'b0; bus.pmem_rdata = '0;
    model_reset();

    repeat (3) @(negedge clk);
    #1;
    chk("rst_mem_resp", bus.mem_resp, 1'b0);
    chk("rst_pmem_read", bus.pmem_read, 1'b0);
    chk("rst_pmem_write", bus.pmem_write, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("idle_mem_resp", bus.mem_resp, 1'b0);
    chk("idle_pmem_read", bus.pmem_read, 1'b0);
    chk("idle_pmem_write", bus.pmem_write, 1'b0);
    chk("idle_rdata", bus.mem_rdata, 32'h0);

    preload_word1(32'h0000_1040, 32'hDEAD_BEEF);
    access(0, 0, 32'h0000_1044, 32'h0, 4'h0);           // cold read
    access(0, 0, 32'h0000_1044, 32'h0, 4'h0);           // hit
    access(1, 0, 32'h0000_1044, 32'h1122_3344, 4'b0101);
    access(0, 0, 32'h0000_1044, 32'h0, 4'h0);           // reads 0xDE22BE44
    access(0, 0, 32'h0000_2044, 32'h0, 4'h0);           // dirty eviction
    access(0, 0, 32'h0000_1044, 32'h0, 4'h0);           // clean eviction
    access(1, 0, 32'h0000_1048, 32'hFFFF_FFFF, 4'b0000); // empty enables still dirty the line
    access(0, 0, 32'h0000_3040, 32'h0, 4'h0);

    // Reset while a fill is outstanding.
    @(negedge clk);
    bus.mem_read = 1'b1;
    bus.mem_address = 32'h0000_5048;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      #1;
      if (bus.pmem_read) seen = 1;
      else @(negedge clk);
    end
    chk("rst_fill_started", seen, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_pmem_read", bus.pmem_read, 1'b0);
    chk("rst_async_pmem_write", bus.pmem_write, 1'b0);
    chk("rst_async_mem_resp", bus.mem_resp, 1'b0);
    bus.mem_read = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    access(0, 0, 32'h0000_5048, 32'h0, 4'h0);
    access(0, 0, 32'h0000_3044, 32'h0, 4'h0);

    for (int n = 0; n < 80; n++) begin
      addr = 32'h0001_0000 | ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 5)
           | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      wr     = 1'($urandom_range(0, 1));
      rd_too = wr && ($urandom_range(0, 9) == 0);
      access(wr, rd_too, addr, $urandom, 4'($urandom_range(0, 15)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
